// File: rtl/mult_control_fsm_if.sv
// Control/status bundle between the multiply datapath and its sequencing FSM.
// start/count are sampled on the rising clock edge; all other fields are driven by the FSM.
interface mult_control_fsm_if;
    logic       start;
    logic [1:0] count;
    logic       done;
    logic       clk_ena;
    logic       sclr_n;
    logic [2:0] state_out;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;

    modport master (
        output start, count,
        input  done, clk_ena, sclr_n, state_out, input_sel, shift_sel
    );

    modport slave (
        input  start, count,
        output done, clk_ena, sclr_n, state_out, input_sel, shift_sel
    );
endinterface

// File: rtl/mult_control_fsm.sv
// Sequencer for an 8x8 multiply built from four 4x4 partial products.
// Moore state register with Mealy control outputs; state_out exposes the registered state.
module mult_control_fsm (
    input logic              clk,
    input logic              reset_a,
    mult_control_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        LSB       = 3'b001,
        MID       = 3'b010,
        MSB       = 3'b011,
        CALC_DONE = 3'b100,
        ERR       = 3'b101
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       done;
    logic       clk_ena;
    logic       sclr_n;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        clk_ena    = 1'b0;
        sclr_n     = 1'b1;
        input_sel  = 2'b00;
        shift_sel  = 2'b00;
        case (state)
            IDLE, ERR: begin
                if (bus.start) begin
                    clk_ena    = 1'b1;
                    sclr_n     = 1'b0;
                    state_next = LSB;
                end
            end
            LSB: begin
                if (!bus.start && bus.count == 2'b00) begin
                    clk_ena    = 1'b1;
                    state_next = MID;
                end else begin
                    state_next = ERR;
                end
            end
            MID: begin
                // The two cross products share the 4-bit shift; count picks which one.
                if (!bus.start && bus.count == 2'b01) begin
                    input_sel  = 2'b01;
                    shift_sel  = 2'b01;
                    clk_ena    = 1'b1;
                    state_next = MID;
                end else if (!bus.start && bus.count == 2'b10) begin
                    input_sel  = 2'b10;
                    shift_sel  = 2'b01;
                    clk_ena    = 1'b1;
                    state_next = MSB;
                end else begin
                    state_next = ERR;
                end
            end
            MSB: begin
                if (!bus.start && bus.count == 2'b11) begin
                    input_sel  = 2'b11;
                    shift_sel  = 2'b10;
                    clk_ena    = 1'b1;
                    state_next = CALC_DONE;
                end else begin
                    state_next = ERR;
                end
            end
            CALC_DONE: begin
                done       = 1'b1;
                state_next = bus.start ? ERR : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.state_out = state;
    assign bus.done      = done;
    assign bus.clk_ena   = clk_ena;
    assign bus.sclr_n    = sclr_n;
    assign bus.input_sel = input_sel;
    assign bus.shift_sel = shift_sel;

endmodule

// File: tb/tb_mult_control_fsm.sv
// Directed bench for mult_control_fsm: reset, a normal multiply, error entry/recovery
// and asynchronous reset in the middle of an operation.
module tb_mult_control_fsm;

    logic clk;
    logic reset_a;
    int   total;
    int   bad;
    logic [7:0] exp_q[$];

    mult_control_fsm_if bus ();

    mult_control_fsm dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compares every FSM output against one expected vector.
    task automatic check_outs(input string tag, input logic [2:0] st, input logic dn,
                              input logic ce, input logic sc, input logic [1:0] is,
                              input logic [1:0] ss);
        check({tag, ".state"},     8'(bus.state_out), 8'(st));
        check({tag, ".done"},      8'(bus.done),      8'(dn));
        check({tag, ".clk_ena"},   8'(bus.clk_ena),   8'(ce));
        check({tag, ".sclr_n"},    8'(bus.sclr_n),    8'(sc));
        check({tag, ".input_sel"}, 8'(bus.input_sel), 8'(is));
        check({tag, ".shift_sel"}, 8'(bus.shift_sel), 8'(ss));
    endtask

    task automatic drive(input logic s, input logic [1:0] c);
        bus.start = s;
        bus.count = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_a   = 1'b0;
        bus.start = 1'b0;
        bus.count = 2'b00;

        // Reset held for several cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("rst", 3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        reset_a = 1'b1;
        tick();
        tick();
        check_outs("post_rst", 3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);

        // Normal multiply
        exp_q = {8'h01, 8'h02, 8'h02, 8'h03, 8'h04, 8'h00};
        drive(1'b1, 2'b00);
        check_outs("idle_start", 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        tick(); drive(1'b0, 2'b00);
        check("seq_lsb", 8'(bus.state_out), exp_q.pop_front());
        check_outs("lsb", 3'b001, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
        tick(); drive(1'b0, 2'b01);
        check("seq_mid1", 8'(bus.state_out), exp_q.pop_front());
        check_outs("mid1", 3'b010, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01);
        tick(); drive(1'b0, 2'b10);
        check("seq_mid2", 8'(bus.state_out), exp_q.pop_front());
        check_outs("mid2", 3'b010, 1'b0, 1'b1, 1'b1, 2'b10, 2'b01);
        tick(); drive(1'b0, 2'b11);
        check("seq_msb", 8'(bus.state_out), exp_q.pop_front());
        check_outs("msb", 3'b011, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10);
        tick(); drive(1'b0, 2'b00);
        check("seq_done", 8'(bus.state_out), exp_q.pop_front());
        check_outs("calc_done", 3'b100, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        check("seq_idle", 8'(bus.state_out), exp_q.pop_front());
        check_outs("back_idle", 3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);

        // start held for two cycles: IDLE -> LSB -> ERR
        drive(1'b1, 2'b00);
        tick();
        check_outs("lsb_start_hi", 3'b001, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        tick(); drive(1'b0, 2'b00);
        check_outs("err_idle", 3'b101, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        check("err_hold", 8'(bus.state_out), 8'h05);

        // Recovery from ERR
        drive(1'b1, 2'b00);
        check_outs("err_start", 3'b101, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        tick(); drive(1'b0, 2'b00);
        check("err_to_lsb", 8'(bus.state_out), 8'h01);

        // Illegal count in MID
        tick(); drive(1'b0, 2'b11);
        check_outs("mid_bad_cnt", 3'b010, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        tick(); drive(1'b0, 2'b00);
        check("mid_to_err", 8'(bus.state_out), 8'h05);

        // start in CALC_DONE goes to ERR
        drive(1'b1, 2'b00); tick();
        drive(1'b0, 2'b00); tick();
        drive(1'b0, 2'b01); tick();
        drive(1'b0, 2'b10); tick();
        drive(1'b0, 2'b11); tick();
        drive(1'b1, 2'b00);
        check_outs("done_start", 3'b100, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
        tick(); drive(1'b0, 2'b00);
        check("done_to_err", 8'(bus.state_out), 8'h05);

        // Asynchronous reset while in MSB
        drive(1'b1, 2'b00); tick();
        drive(1'b0, 2'b00); tick();
        drive(1'b0, 2'b10); tick();
        drive(1'b0, 2'b11);
        check("pre_async_msb", 8'(bus.state_out), 8'h03);
        #1 reset_a = 1'b0;
        drive(1'b0, 2'b00);
        check_outs("async_rst", 3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        @(negedge clk);
        reset_a = 1'b1;
        tick();
        check("after_async", 8'(bus.state_out), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
